// File: rtl/dm_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package dm_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } state_t;

  // Size 11 is never legal, so it reports as misaligned too.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Lane steering for the LSU: merges store data into a read word and
// extracts/extends the addressed lane of a read word for loads.
module lsu_byte_lane
  import dm_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [1:0]  lane,
  output logic [31:0] merged,
  output logic [31:0] extracted
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lanes are little-endian: byte k sits at bits [8k+7:8k].
  always_comb begin
    byte_sel  = word[{lane, 3'b000} +: 8];
    half_sel  = word[{lane[1], 4'b0000} +: 16];
    merged    = word;
    extracted = word;
    case (size)
      SZ_BYTE: begin
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
        extracted = {{24{sext & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        extracted = {{16{sext & half_sel[15]}}, half_sel};
      end
      default: begin
        merged    = wdata;
        extracted = word;
      end
    endcase
  end

endmodule

// File: rtl/dm_lsu.sv
// Load/store initiator for the word-only data memory: alignment checks,
// read-modify-write for sub-word stores, sub-word load extraction.
module dm_lsu
  import dm_lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       PC,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              dm_memw,
  output logic              dm_memr,
  output logic [ADDR_W-1:0] dm_add,
  output logic [31:0]       dm_wdata,
  output logic [31:0]       dm_PC,
  input  logic [31:0]       dm_rdata
);

  state_t             state, state_nx;
  logic               we_q, sext_q, err_q;
  logic [1:0]         size_q;
  logic [ADDR_W+1:0]  addr_q;
  logic [31:0]        wdata_q, pc_q, merge_q;
  logic [31:0]        merged, extracted;
  logic               accept, bad;

  assign accept   = (state == ST_IDLE) && req;
  assign bad      = misaligned(size, addr[1:0]) || ((addr >> (ADDR_W + 2)) != 32'd0);
  assign dm_add   = addr_q[ADDR_W+1:2];
  assign dm_PC    = pc_q;

  lsu_byte_lane u_lane (
    .word      (dm_rdata),
    .wdata     (wdata_q),
    .size      (size_q),
    .sext      (sext_q),
    .lane      (addr_q[1:0]),
    .merged    (merged),
    .extracted (extracted)
  );

  always_ff @(posedge clk) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Word stores skip the read; rejected requests go straight to RESP.
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    dm_memr  = 1'b0;
    dm_memw  = 1'b0;
    dm_wdata = '0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (req) begin
          if (bad)                       state_nx = ST_RESP;
          else if (we && size == SZ_WORD) state_nx = ST_WR;
          else                           state_nx = ST_RD;
        end
      end
      ST_RD: begin
        dm_memr  = 1'b1;
        state_nx = we_q ? ST_WR : ST_RESP;
      end
      ST_WR: begin
        dm_memw  = ~clr;
        dm_wdata = (size_q == SZ_WORD) ? wdata_q : merge_q;
        state_nx = ST_RESP;
      end
      ST_RESP: begin
        done     = 1'b1;
        err      = err_q;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Request capture, merge word for RMW stores, and the held load result.
  always_ff @(posedge clk) begin
    if (clr) begin
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      merge_q <= '0;
      rdata   <= '0;
    end else begin
      if (accept) begin
        we_q    <= we;
        sext_q  <= sext;
        err_q   <= bad;
        size_q  <= size;
        addr_q  <= addr[ADDR_W+1:0];
        wdata_q <= wdata;
        pc_q    <= PC;
      end
      if (state == ST_RD) begin
        if (we_q) merge_q <= merged;
        else      rdata   <= extracted;
      end
    end
  end

endmodule

// File: tb/tb_dm_lsu.sv
// Self-checking bench for dm_lsu: directed vector table, clear-during-RMW
// sequence, and randomized traffic against a byte-addressed reference model.
module tb_dm_lsu;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [1:0]    size = 2'b00;
  logic          sext = 1'b0;
  logic [31:0]   addr = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   pc = '0;
  logic          ready, done, err, dm_memw, dm_memr;
  logic [31:0]   rdata, dm_wdata, dm_PC, dm_rdata;
  logic [AW-1:0] dm_add;

  int checks = 0;
  int failures = 0;

  logic [31:0] dmMem [1024];
  logic [7:0]  refMem [4096];
  logic [31:0] refRdata;

  always #5 clk = ~clk;

  dm_lsu #(.ADDR_W(AW)) dut (
    .clk(clk), .clr(clr), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .PC(pc), .ready(ready), .done(done), .err(err),
    .rdata(rdata), .dm_memw(dm_memw), .dm_memr(dm_memr), .dm_add(dm_add),
    .dm_wdata(dm_wdata), .dm_PC(dm_PC), .dm_rdata(dm_rdata)
  );

  // Data memory: synchronous write, combinational read, cleared by reset.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) dmMem[i] <= '0;
    end else if (dm_memw) begin
      dmMem[dm_add] <= dm_wdata;
    end
  end
  assign dm_rdata = dm_memr ? dmMem[dm_add] : 32'hA5A5_A5A5;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        expErr;
    logic [31:0] expRdata;
    int          expLat;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mkVec(logic w, logic [1:0] s, logic x, logic [31:0] a,
                                 logic [31:0] d, logic e, logic [31:0] r, int l);
    vec_t v;
    v.we = w; v.size = s; v.sext = x; v.addr = a; v.wdata = d;
    v.expErr = e; v.expRdata = r; v.expLat = l;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issues one request, follows it to done, reports latency and what the DM ports did.
  task automatic applyStimulus(input logic iWe, input logic [1:0] iSize, input logic iSext,
                               input logic [31:0] iAddr, input logic [31:0] iWdata,
                               input logic [31:0] iPc, input bit holdReq,
                               output int lat, output logic gotErr, output logic [31:0] gotRdata,
                               output logic sawMem, output logic sawBoth,
                               output logic [AW-1:0] wAdd, output logic [31:0] wData,
                               output logic [31:0] wPc);
    int n;
    @(negedge clk);
    req = 1'b1; we = iWe; size = iSize; sext = iSext; addr = iAddr; wdata = iWdata; pc = iPc;
    n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) checkOutput("ready_timeout", 32'(ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    lat = 0; sawMem = 1'b0; sawBoth = 1'b0; wAdd = '0; wData = '0; wPc = '0;
    while (!done && lat < 20) begin
      if (dm_memr || dm_memw) sawMem = 1'b1;
      if (dm_memr && dm_memw) sawBoth = 1'b1;
      if (dm_memw) begin
        wAdd = dm_add; wData = dm_wdata; wPc = dm_PC;
      end
      if (holdReq) begin
        we = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom; pc = $urandom;
      end
      @(negedge clk);
      lat++;
    end
    if (!done) checkOutput("done_timeout", 32'(done), 32'd1);
    gotErr = err;
    gotRdata = rdata;
    if (!holdReq) req = 1'b0;
  endtask

  task automatic doReset();
    req = 1'b0;
    clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
  endtask

  function automatic logic isBad(logic [1:0] s, logic [31:0] a);
    return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00)
           || (a >= 32'd4096);
  endfunction

  function automatic logic [31:0] refLoad(logic [1:0] s, logic x, logic [31:0] a);
    logic [31:0] v;
    if (s == 2'b00) begin
      v = {24'd0, refMem[a[11:0]]};
      if (x && v[7]) v = v + 32'hFFFF_FF00;
    end else if (s == 2'b01) begin
      v = {16'd0, refMem[a[11:0] + 12'd1], refMem[a[11:0]]};
      if (x && v[15]) v = v + 32'hFFFF_0000;
    end else begin
      v = {refMem[a[11:0] + 12'd3], refMem[a[11:0] + 12'd2], refMem[a[11:0] + 12'd1], refMem[a[11:0]]};
    end
    return v;
  endfunction

  task automatic refStore(logic [1:0] s, logic [31:0] a, logic [31:0] d);
    int nbytes;
    nbytes = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    for (int k = 0; k < nbytes; k++) refMem[a[11:0] + 12'(k)] = d[8*k +: 8];
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    logic gErr, gMem, gBoth;
    logic [31:0] gRd, wData, wPc;
    logic [AW-1:0] wAdd;

    vecs[0]  = mkVec(0, 2'b10, 0, 32'h10,   0,        0, 32'hDEADBEEF, 1);
    vecs[1]  = mkVec(1, 2'b00, 0, 32'h11,   32'h55,   0, 32'hDEADBEEF, 2);
    vecs[2]  = mkVec(0, 2'b10, 0, 32'h10,   0,        0, 32'hDEAD55EF, 1);
    vecs[3]  = mkVec(0, 2'b00, 1, 32'h13,   0,        0, 32'hFFFFFFDE, 1);
    vecs[4]  = mkVec(0, 2'b00, 0, 32'h13,   0,        0, 32'h000000DE, 1);
    vecs[5]  = mkVec(1, 2'b01, 0, 32'h12,   32'h1234, 0, 32'h000000DE, 2);
    vecs[6]  = mkVec(0, 2'b01, 0, 32'h12,   0,        0, 32'h00001234, 1);
    vecs[7]  = mkVec(0, 2'b01, 1, 32'h10,   0,        0, 32'h000055EF, 1);
    vecs[8]  = mkVec(0, 2'b00, 1, 32'h11,   0,        0, 32'h00000055, 1);
    vecs[9]  = mkVec(0, 2'b10, 0, 32'h22,   0,        1, 32'h00000055, 0);
    vecs[10] = mkVec(1, 2'b01, 0, 32'h13,   32'hFFFF, 1, 32'h00000055, 0);
    vecs[11] = mkVec(0, 2'b11, 0, 32'h10,   0,        1, 32'h00000055, 0);
    vecs[12] = mkVec(0, 2'b10, 0, 32'h1000, 0,        1, 32'h00000055, 0);

    doReset();
    checkOutput("rst_ready", 32'(ready), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_mem_en", {30'd0, dm_memr, dm_memw}, 32'd0);
    checkOutput("rst_dm_add", 32'(dm_add), 32'd0);
    checkOutput("rst_dm_wdata", dm_wdata, 32'd0);
    checkOutput("rst_dm_pc", dm_PC, 32'd0);

    // Word store goes straight to a single WR cycle.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0000_0400, 1'b0,
                  lat, gErr, gRd, gMem, gBoth, wAdd, wData, wPc);
    checkOutput("sw_lat", 32'(lat), 32'd1);
    checkOutput("sw_err", 32'(gErr), 32'd0);
    checkOutput("sw_dm_add", 32'(wAdd), 32'd4);
    checkOutput("sw_dm_wdata", wData, 32'hDEADBEEF);
    checkOutput("sw_dm_pc", wPc, 32'h0000_0400);
    checkOutput("sw_mem4", dmMem[4], 32'hDEADBEEF);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].we, vecs[i].size, vecs[i].sext, vecs[i].addr, vecs[i].wdata,
                    32'h100 + 32'(i), 1'b0, lat, gErr, gRd, gMem, gBoth, wAdd, wData, wPc);
      checkOutput($sformatf("vec%0d_err", i), 32'(gErr), 32'(vecs[i].expErr));
      checkOutput($sformatf("vec%0d_rdata", i), gRd, vecs[i].expRdata);
      checkOutput($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].expLat));
      checkOutput($sformatf("vec%0d_both", i), 32'(gBoth), 32'd0);
      if (vecs[i].expErr) checkOutput($sformatf("vec%0d_nomem", i), 32'(gMem), 32'd0);
    end
    checkOutput("mem4_after_rmw", dmMem[4], 32'h123455EF);

    // Clear during the write half of a byte RMW must suppress the write.
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; sext = 1'b0; addr = 32'h20; wdata = 32'hAB;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    checkOutput("clr_rd_phase", {30'd0, dm_memr, dm_memw}, 32'd2);
    @(negedge clk);
    checkOutput("clr_wr_phase", 32'(dm_memw), 32'd1);
    clr = 1'b1;
    #1;
    checkOutput("clr_gates_memw", 32'(dm_memw), 32'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    checkOutput("clr_ready", 32'(ready), 32'd1);
    checkOutput("clr_done", 32'(done), 32'd0);
    checkOutput("clr_rdata", rdata, 32'd0);
    checkOutput("clr_mem_en", {30'd0, dm_memr, dm_memw}, 32'd0);
    checkOutput("clr_mem8", dmMem[8], 32'd0);

    // Randomized traffic with req held high against the byte-level model.
    doReset();
    for (int i = 0; i < 4096; i++) refMem[i] = 8'd0;
    refRdata = 32'd0;
    for (int i = 0; i < 40; i++) begin
      logic        rWe, rSx, rBad;
      logic [1:0]  rSz;
      logic [31:0] rA, rD;
      int          expLat;
      rWe = 1'($urandom);
      rSx = 1'($urandom);
      rSz = 2'($urandom_range(0, 3));
      rA  = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) rA = rA | (32'd1 << $urandom_range(12, 31));
      rD  = $urandom;
      rBad = isBad(rSz, rA);
      applyStimulus(rWe, rSz, rSx, rA, rD, $urandom, 1'b1,
                    lat, gErr, gRd, gMem, gBoth, wAdd, wData, wPc);
      if (rBad)                   expLat = 0;
      else if (!rWe)              expLat = 1;
      else if (rSz == 2'b10)      expLat = 1;
      else                        expLat = 2;
      if (!rBad) begin
        if (rWe) refStore(rSz, rA, rD);
        else     refRdata = refLoad(rSz, rSx, rA);
      end
      checkOutput($sformatf("rnd%0d_err", i), 32'(gErr), 32'(rBad));
      checkOutput($sformatf("rnd%0d_rdata", i), gRd, refRdata);
      checkOutput($sformatf("rnd%0d_lat", i), 32'(lat), 32'(expLat));
      checkOutput($sformatf("rnd%0d_both", i), 32'(gBoth), 32'd0);
    end
    @(negedge clk);
    req = 1'b0;
    for (int w = 0; w < 16; w++) begin
      checkOutput($sformatf("rnd_mem%0d", w), dmMem[w],
                  {refMem[4*w+3], refMem[4*w+2], refMem[4*w+1], refMem[4*w]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
